obs_capture: RTL and testbench
==============================

OBS_CAPTURE -- requirements
Module: obs_capture

Interface
REQ-001 Parameter DEPTH, default 8: capture buffer entries; power of two, minimum 2.
REQ-002 Parameter STAMP_W, default 32: cycle-stamp width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 obs  input  1  observation strobe from the stimulus side; data is sampled in the same cycle it is high.
REQ-006 data  input  128  DUT result word (AES out).
REQ-007 rd_ready  input  1  consumer accepts the head entry.
REQ-008 rd_valid  output  1  head entry available.
REQ-009 rd_data  output  128  head entry data word.
REQ-010 rd_stamp  output  STAMP_W  cycle stamp of the head entry.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 overflow  output  1  sticky flag: an obs sample was dropped.
REQ-013 sig  output  128  running signature; present only with OBS_CAPTURE_SIG_EN.

Function
REQ-014 The stamp counter shall be 0 in the first cycle after rst deasserts, shall increment by 1 every cycle, and shall wrap from all-ones to 0.
REQ-015 A push shall occur when obs=1 and either count<DEPTH or a pop occurs in the same cycle; the pushed entry is {stamp of that cycle, data}.
REQ-016 A pop shall occur when rd_valid=1 and rd_ready=1.
REQ-017 rd_valid shall equal (count!=0); rd_data and rd_stamp shall present the oldest entry (show-ahead).
REQ-018 Push-to-visible latency shall be 1 cycle: an entry pushed in cycle N appears on rd_valid/rd_data no earlier than cycle N+1, with no same-cycle bypass when empty.
REQ-019 Simultaneous push and pop shall leave count unchanged at any occupancy, including full.
REQ-020 obs=1 when count==DEPTH and no pop shall drop the sample, leave the buffer unchanged and set overflow.
REQ-021 overflow shall stay set until rst.
REQ-022 Read and write pointers shall wrap modulo DEPTH.
REQ-023 rd_ready while rd_valid=0 shall have no effect.
REQ-024 Outputs on an empty buffer: rd_data and rd_stamp hold their last values; the bench shall not check them.

Reset
REQ-025 rst=1 shall force count=0, rd_valid=0, overflow=0, pointers=0, stamp=0, and sig=0 (when compiled in).
REQ-026 rst asserted mid-operation shall discard all entries and ignore obs and rd_ready in that cycle.
REQ-027 Buffer storage contents need no reset.

Configuration
REQ-028 Macro OBS_CAPTURE_SIG_EN shall control the signature feature.
REQ-029 With OBS_CAPTURE_SIG_EN defined:
- every cycle with obs=1, including dropped samples, sig <= {sig[126:0], sig[127]} ^ data.
REQ-030 With OBS_CAPTURE_SIG_EN undefined:
- the sig port and its register shall not exist;
- all other behaviour is identical.

Structure
REQ-031 Package obs_capture_pkg shall hold:
- DATA_W=128 and the DEPTH default;
- the entry typedef {stamp, data};
- the signature-update function.
REQ-032 Sub-module obs_capture_fifo shall implement the storage, pointers and count.
REQ-033 The top level shall hold the stamp counter, the overflow flag and the signature.

Verification
REQ-034 Reset, then idle for 5 cycles -> rd_valid=0, count=0, overflow=0, sig=0.
REQ-035 obs=1 at stamp 3 with data=128'h0123...CDEF, rd_ready=0 -> at stamp 4: rd_valid=1, rd_data=128'h0123...CDEF, rd_stamp=3, count=1.
REQ-036 Fill: obs=1 for 9 consecutive cycles with data=1..9, rd_ready=0, DEPTH=8 -> count=8, overflow=1, then popping yields data 1..8 in order.
REQ-037 Full buffer with obs=1 and rd_ready=1 in the same cycle -> count stays 8, the head advances, and the new entry lands at the tail.
REQ-038 With the macro defined, samples 128'h1 then 128'h2 from reset -> sig=128'h1, then sig=128'h0 (rotated 128'h1 = 128'h2, XOR 128'h2).
REQ-039 rst asserted with count=5 and obs=1 -> next cycle count=0, rd_valid=0, stamp=0.

Source files
------------

// File: rtl/obs_capture_pkg.sv
// Shared definitions for the observation capture buffer: data width,
// default depth, entry layout and the running-signature update.
package obs_capture_pkg;

  localparam int DATA_W      = 128;
  localparam int DEPTH_DEF   = 8;
  localparam int STAMP_W_DEF = 32;

  // Entry layout at the default stamp width; stamp sits above data so the
  // packed word is {stamp, data}. The top builds the same layout at STAMP_W.
  typedef struct packed {
    logic [STAMP_W_DEF-1:0] stamp;
    logic [DATA_W-1:0]      data;
  } entry_t;

  // Rotate-left-by-one then fold in the new sample.
  function automatic logic [DATA_W-1:0] sig_next(input logic [DATA_W-1:0] sig,
                                                 input logic [DATA_W-1:0] data);
    return {sig[DATA_W-2:0], sig[DATA_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/obs_capture_fifo.sv
// Show-ahead circular buffer with occupancy count. A push into a full
// buffer is accepted only when a pop frees the head in the same cycle;
// otherwise the sample is reported on drop.
module obs_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 160
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   obs,
  input  logic                   rd_ready,
  input  logic [W-1:0]           wdata,
  output logic                   rd_valid,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          full, push, pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign push     = obs & (~full | pop);
  assign drop     = obs & full & ~pop;

  // When empty, rd_ptr-1 still holds the last popped entry (the next push
  // lands at rd_ptr), so the outputs keep their last shown value.
  assign rdata = rd_valid ? mem[rd_ptr] : mem[rd_ptr - AW'(1)];

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obs_capture.sv
// Observation capture: stamps each obs sample with a free-running cycle
// counter and queues {stamp, data} for a downstream consumer. Drops when
// full are latched in a sticky overflow flag.
// Optional feature: define OBS_CAPTURE_SIG_EN to add a running signature
// of every observed data word on the sig port.
module obs_capture
  import obs_capture_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int STAMP_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   obs,
  input  logic [DATA_W-1:0]      data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [STAMP_W-1:0]     rd_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef OBS_CAPTURE_SIG_EN
  ,
  output logic [DATA_W-1:0]      sig
`endif
);

  localparam int EW = STAMP_W + DATA_W;

  logic [STAMP_W-1:0] stamp;
  logic [EW-1:0]      head;
  logic               drop;

  obs_capture_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .obs      (obs),
    .rd_ready (rd_ready),
    .wdata    ({stamp, data}),
    .rd_valid (rd_valid),
    .rdata    (head),
    .count    (count),
    .drop     (drop)
  );

  assign {rd_stamp, rd_data} = head;

  // Free-running cycle stamp; reads 0 in the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) stamp <= '0;
    else     stamp <= stamp + 1'b1;
  end

  // Sticky record that at least one sample was dropped.
  always_ff @(posedge clk) begin
    if (rst)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef OBS_CAPTURE_SIG_EN
  // Signature covers every observed word, dropped ones included.
  always_ff @(posedge clk) begin
    if (rst)      sig <= '0;
    else if (obs) sig <= sig_next(sig, data);
  end
`endif

endmodule

// File: tb/tb_obs_capture.sv
// Self-checking bench for obs_capture: a queue-based model of the capture
// buffer is compared against the DUT every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_obs_capture;

  localparam int DEPTH   = 8;
  localparam int STAMP_W = 32;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst, obs, rd_ready;
  logic [127:0]       data;
  logic               rd_valid, overflow;
  logic [127:0]       rd_data;
  logic [STAMP_W-1:0] rd_stamp;
  logic [CW-1:0]      count;
`ifdef OBS_CAPTURE_SIG_EN
  logic [127:0]       sig;
`endif

  obs_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .obs      (obs),
    .data     (data),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_stamp (rd_stamp),
    .count    (count),
    .overflow (overflow)
`ifdef OBS_CAPTURE_SIG_EN
    ,
    .sig      (sig)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [STAMP_W-1:0] st;
    logic [127:0]       d;
  } ent_t;

  ent_t               q[$];
  logic [STAMP_W-1:0] m_stamp;
  logic               m_ovf;
  logic [127:0]       m_sig;
  bit                 armed = 0;
  int                 checks = 0;
  int                 errs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Model: one clock edge worth of behaviour, applied from the inputs.
  task automatic model_step(input bit r, input bit o, input logic [127:0] d, input bit rr);
    bit pop, push;
    if (r) begin
      q.delete();
      m_stamp = '0;
      m_ovf   = 1'b0;
      m_sig   = '0;
      armed   = 1;
    end else begin
      pop  = (q.size() > 0) && rr;
      push = o && ((q.size() < DEPTH) || pop);
      if (o && !push) m_ovf = 1'b1;
      if (o) m_sig = {m_sig[126:0], m_sig[127]} ^ d;
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{st: m_stamp, d: d});
      m_stamp = m_stamp + 1'b1;
    end
  endtask

  // Compare all meaningful outputs against the model.
  task automatic check_all();
    if (armed) begin
      chk("rd_valid", 128'(rd_valid), 128'(q.size() != 0));
      chk("count", 128'(count), 128'(q.size()));
      chk("overflow", 128'(overflow), 128'(m_ovf));
      if (q.size() != 0) begin
        chk("rd_data", rd_data, q[0].d);
        chk("rd_stamp", 128'(rd_stamp), 128'(q[0].st));
      end
`ifdef OBS_CAPTURE_SIG_EN
      chk("sig", sig, m_sig);
`endif
    end
  endtask

  // Drive inputs at negedge, let one posedge happen, check at next negedge.
  task automatic cyc(input bit r, input bit o, input logic [127:0] d, input bit rr);
    rst = r; obs = o; data = d; rd_ready = rr;
    @(posedge clk);
    model_step(r, o, d, rr);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int po_tab[6] = '{90, 50, 10, 100, 70, 30};
  int pr_tab[6] = '{10, 50, 90, 100, 30, 70};

  initial begin
    logic [127:0] k;
    int po, pr;
    rst = 1'b1; obs = 1'b0; data = '0; rd_ready = 1'b0;
    @(negedge clk);

    // Reset then idle five cycles.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0);
    chk("idle_valid", 128'(rd_valid), 128'd0);
    chk("idle_count", 128'(count), 128'd0);
    chk("idle_ovf", 128'(overflow), 128'd0);
`ifdef OBS_CAPTURE_SIG_EN
    chk("idle_sig", sig, 128'd0);
`endif

    // Single sample at stamp 3.
    k = 128'h0123456789ABCDEF0123456789ABCDEF;
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    cyc(0, 1, k, 0);
    chk("one_valid", 128'(rd_valid), 128'd1);
    chk("one_data", rd_data, k);
    chk("one_stamp", 128'(rd_stamp), 128'd3);
    chk("one_count", 128'(count), 128'd1);
    chk("model_stamp", 128'(q[0].st), 128'd3);

    // Fill with nine samples: eight kept, ninth dropped.
    cyc(1, 0, '0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 1, 128'(i), 0);
    chk("fill_count", 128'(count), 128'd8);
    chk("fill_ovf", 128'(overflow), 128'd1);
    chk("model_fill", 128'(q.size()), 128'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("fill_order", rd_data, 128'(i));
      cyc(0, 0, '0, 1);
    end
    chk("drained_valid", 128'(rd_valid), 128'd0);
    chk("ovf_sticky", 128'(overflow), 128'd1);
    cyc(0, 0, '0, 1);  // rd_ready on empty is a no-op
    chk("empty_rdy_count", 128'(count), 128'd0);

    // Full buffer with simultaneous push and pop.
    cyc(1, 0, '0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 128'(i), 0);
    cyc(0, 1, 128'hAA, 1);
    chk("full_pp_count", 128'(count), 128'd8);
    chk("full_pp_head", rd_data, 128'd2);
    chk("full_pp_ovf", 128'(overflow), 128'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, '0, 1);
    chk("full_pp_tail", rd_data, 128'hAA);
    chk("full_pp_tail_stamp", 128'(rd_stamp), 128'd8);
    cyc(0, 0, '0, 1);

`ifdef OBS_CAPTURE_SIG_EN
    // Signature of 1 then 2.
    cyc(1, 0, '0, 0);
    cyc(0, 1, 128'h1, 0);
    chk("sig_1", sig, 128'h1);
    cyc(0, 1, 128'h2, 0);
    chk("sig_2", sig, 128'h0);
`endif

    // Reset mid-operation with obs and rd_ready active.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, rnd128(), 0);
    chk("pre_rst_count", 128'(count), 128'd5);
    cyc(1, 1, rnd128(), 1);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_valid", 128'(rd_valid), 128'd0);
    k = 128'h5A5A;
    cyc(0, 1, k, 0);
    chk("rst_stamp0", 128'(rd_stamp), 128'd0);
    chk("rst_data", rd_data, k);

    // Randomized traffic in phases of varying push/pop pressure.
    for (int ph = 0; ph < 6; ph++) begin
      po = po_tab[ph];
      pr = pr_tab[ph];
      for (int i = 0; i < 500; i++)
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 99) < po, rnd128(),
            $urandom_range(0, 99) < pr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
